// File: rtl/digit_text_renderer.sv
// Draws one row of up to NCHARS glyphs from the 8x16 digit ROM, 3-cycle pixel pipeline.
// Double-buffered glyph string: the pending buffer is copied to the active buffer at frame start.
module digit_text_renderer #(
   parameter int unsigned X0          = 64,
   parameter int unsigned Y0          = 32,
   parameter int unsigned NCHARS      = 8,
   parameter int unsigned SCALE_SHIFT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        video_on,
   input  logic        frame_start,
   input  logic        wr_en,
   input  logic [2:0]  wr_idx,
   input  logic [3:0]  wr_glyph,
   input  logic        commit,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        pixel_on,
   output logic        committed
);

   localparam int unsigned CHAR_W     = 8 << SCALE_SHIFT;
   localparam int unsigned BOX_H      = 16 << SCALE_SHIFT;
   localparam int unsigned X_END      = X0 + NCHARS * CHAR_W;
   localparam int unsigned Y_END      = Y0 + BOX_H;
   localparam int unsigned CHAR_SHIFT = 3 + SCALE_SHIFT;
   localparam logic [3:0]  BLANK      = 4'hF;
   localparam logic [10:0] ROM_BASE   = 11'h300;

   logic [7:0][3:0] pending_q, pending_d;
   logic [7:0][3:0] active_q, active_d;
   logic            commit_pend_q, commit_pend_d;
   logic            committed_q, committed_d;
   logic [10:0]     rom_addr_q, rom_addr_d;
   logic            vis1_q, vis1_d;
   logic [2:0]      col1_q, col1_d;
   logic            vis2_q, vis2_d;
   logic [2:0]      col2_q, col2_d;
   logic            pixel_on_q, pixel_on_d;

   logic [9:0] rx, ry;
   logic       in_box;
   logic [2:0] char_idx;
   logic [2:0] col;
   logic [3:0] row;
   logic [3:0] glyph;
   logic       copy;

   // Region decode and glyph lookup for the pixel entering the pipeline
   always_comb begin
      rx       = x - 10'(X0);
      ry       = y - 10'(Y0);
      in_box   = video_on
               & (x >= 10'(X0)) & ({1'b0, x} < 11'(X_END))
               & (y >= 10'(Y0)) & ({1'b0, y} < 11'(Y_END));
      char_idx = 3'(rx >> CHAR_SHIFT);
      col      = 3'(rx >> SCALE_SHIFT);
      row      = 4'(ry >> SCALE_SHIFT);
      glyph    = active_q[char_idx];
   end

   always_comb begin
      vis1_d     = in_box & (glyph <= 4'd12);
      rom_addr_d = vis1_d ? {3'b011, glyph, row} : ROM_BASE;
      col1_d     = col;
      vis2_d     = vis1_q;
      col2_d     = col1_q;
      pixel_on_d = vis2_q & rom_data[3'd7 - col2_q];
   end

   // Commit handshake: copy sees pending as it was before this edge's write
   always_comb begin
      pending_d     = pending_q;
      active_d      = active_q;
      copy          = frame_start & (commit_pend_q | commit);
      commit_pend_d = commit_pend_q | commit;
      committed_d   = copy;
      if (copy) begin
         active_d      = pending_q;
         commit_pend_d = 1'b0;
      end
      if (wr_en && ({1'b0, wr_idx} < 4'(NCHARS))) begin
         pending_d[wr_idx] = wr_glyph;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q     <= {8{BLANK}};
         active_q      <= {8{BLANK}};
         commit_pend_q <= 1'b0;
         committed_q   <= 1'b0;
         rom_addr_q    <= ROM_BASE;
         vis1_q        <= 1'b0;
         col1_q        <= 3'd0;
         vis2_q        <= 1'b0;
         col2_q        <= 3'd0;
         pixel_on_q    <= 1'b0;
      end else begin
         pending_q     <= pending_d;
         active_q      <= active_d;
         commit_pend_q <= commit_pend_d;
         committed_q   <= committed_d;
         rom_addr_q    <= rom_addr_d;
         vis1_q        <= vis1_d;
         col1_q        <= col1_d;
         vis2_q        <= vis2_d;
         col2_q        <= col2_d;
         pixel_on_q    <= pixel_on_d;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign pixel_on  = pixel_on_q;
   assign committed = committed_q;

endmodule

// File: tb/tb_digit_text_renderer.sv
// Bench for digit_text_renderer: ROM model, integer-arithmetic reference model,
// directed vector table, hand sequences for commit/reset corners, random traffic.
module tb_digit_text_renderer;

   localparam int X0 = 64;
   localparam int Y0 = 32;
   localparam int NCH = 8;
   localparam int SS = 1;
   localparam int SC = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  x, y;
   logic        video_on, frame_start, wr_en, commit;
   logic [2:0]  wr_idx;
   logic [3:0]  wr_glyph;
   logic [10:0] rom_addr;
   logic [7:0]  rom_data;
   logic        pixel_on, committed;

   digit_text_renderer #(.X0(X0), .Y0(Y0), .NCHARS(NCH), .SCALE_SHIFT(SS)) dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
      .frame_start(frame_start), .wr_en(wr_en), .wr_idx(wr_idx),
      .wr_glyph(wr_glyph), .commit(commit), .rom_addr(rom_addr),
      .rom_data(rom_data), .pixel_on(pixel_on), .committed(committed)
   );

   always #5 clk = ~clk;

   logic [7:0] rom [2048];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int vectors = 0;
   int miscompares = 0;
   int act_m [8];
   int pend_m [8];
   bit cp_m;
   bit pixq [$];

   typedef struct {
      int x;
      int y;
      int addr;
      bit pix;
   } vec_t;
   vec_t tbl [15];

   function automatic void model_out(input int xi, input int yi, input bit von,
                                     output int addr, output bit pix);
      int rx = xi - X0;
      int ry = yi - Y0;
      int ch, cl, rw, g;
      addr = 'h300;
      pix  = 1'b0;
      if (von && rx >= 0 && rx < NCH * 8 * SC && ry >= 0 && ry < 16 * SC) begin
         ch = rx / (8 * SC);
         cl = (rx / SC) % 8;
         rw = (ry / SC) % 16;
         g  = act_m[ch];
         if (g <= 12) begin
            addr = 'h300 + g * 16 + rw;
            pix  = rom[addr][7 - cl];
         end
      end
   endfunction

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         act_m[i]  = 15;
         pend_m[i] = 15;
      end
      cp_m = 1'b0;
      pixq.delete();
      pixq.push_back(1'b0);
      pixq.push_back(1'b0);
   endtask

   task automatic idle();
      frame_start = 1'b0;
      wr_en       = 1'b0;
      commit      = 1'b0;
   endtask

   // One clock with current inputs; model predicts and all outputs are checked
   task automatic tick();
      int ea;
      bit ep, ec;
      model_out(int'(x), int'(y), video_on, ea, ep);
      ec = frame_start && (cp_m || commit);
      if (ec) begin
         act_m = pend_m;
         cp_m  = 1'b0;
      end else begin
         cp_m = cp_m || commit;
      end
      if (wr_en && int'(wr_idx) < NCH) pend_m[wr_idx] = int'(wr_glyph);
      pixq.push_back(ep);
      @(posedge clk);
      #1;
      check("rom_addr", int'(rom_addr), ea);
      check("committed", int'(committed), int'(ec));
      check("pixel_on", int'(pixel_on), int'(pixq.pop_front()));
   endtask

   task automatic write(input int idx, input int g);
      idle();
      wr_en    = 1'b1;
      wr_idx   = 3'(idx);
      wr_glyph = 4'(g);
      tick();
      idle();
   endtask

   task automatic pulse_commit(input bit fs, input bit cm);
      idle();
      frame_start = fs;
      commit      = cm;
      tick();
      idle();
   endtask

   task automatic probe(input int xi, input int yi);
      x = 10'(xi);
      y = 10'(yi);
      video_on = 1'b1;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
      rom['h312] = 8'h18;
      rom['h3A6] = 8'h7E;
      rom['h31F] = 8'hFF;

      tbl[0]  = '{64, 36, 'h312, 1'b0};
      tbl[1]  = '{69, 36, 'h312, 1'b0};
      tbl[2]  = '{70, 36, 'h312, 1'b1};
      tbl[3]  = '{73, 36, 'h312, 1'b1};
      tbl[4]  = '{74, 36, 'h312, 1'b0};
      tbl[5]  = '{80, 44, 'h3A6, 1'b0};
      tbl[6]  = '{82, 44, 'h3A6, 1'b1};
      tbl[7]  = '{93, 44, 'h3A6, 1'b1};
      tbl[8]  = '{95, 44, 'h3A6, 1'b0};
      tbl[9]  = '{63, 36, 'h300, 1'b0};
      tbl[10] = '{64, 63, 'h31F, 1'b1};
      tbl[11] = '{64, 64, 'h300, 1'b0};
      tbl[12] = '{191, 36, 'h300, 1'b0};
      tbl[13] = '{192, 36, 'h300, 1'b0};
      tbl[14] = '{70, 31, 'h300, 1'b0};

      reset = 1'b1;
      x = '0; y = '0; video_on = 1'b0;
      wr_idx = '0; wr_glyph = '0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_rom_addr", int'(rom_addr), 'h300);
      check("reset_pixel_on", int'(pixel_on), 0);
      check("reset_committed", int'(committed), 0);
      reset = 1'b0;

      // Blank display sweep; frame_start without commit must not pulse
      video_on = 1'b1;
      for (int yy = 28; yy <= 68; yy += 4) begin
         for (int xx = 56; xx <= 200; xx++) begin
            x = 10'(xx);
            y = 10'(yy);
            frame_start = (xx == 100);
            tick();
         end
      end
      idle();

      // Load slot0='1', slot1='-', double commit collapses into one copy
      write(0, 1);
      write(1, 10);
      pulse_commit(1'b0, 1'b1);
      pulse_commit(1'b0, 1'b1);
      pulse_commit(1'b1, 1'b0);
      check("first_commit_pulse", int'(committed), 1);
      pulse_commit(1'b1, 1'b0);
      check("no_second_pulse", int'(committed), 0);

      for (int i = 0; i < 15; i++) begin
         probe(tbl[i].x, tbl[i].y);
         check("tbl_addr", int'(rom_addr), tbl[i].addr);
         if (i >= 2) check("tbl_pix", int'(pixel_on), int'(tbl[i - 2].pix));
      end
      probe(0, 0);
      check("tbl_pix", int'(pixel_on), int'(tbl[13].pix));
      probe(0, 0);
      check("tbl_pix", int'(pixel_on), int'(tbl[14].pix));

      // Write without commit stays hidden across frame_start
      write(2, 7);
      pulse_commit(1'b1, 1'b0);
      check("uncommitted_no_pulse", int'(committed), 0);
      for (int xx = 96; xx < 112; xx++) probe(xx, 36);
      probe(100, 36);
      check("slot2_hidden", int'(rom_addr), 'h300);
      pulse_commit(1'b0, 1'b1);
      pulse_commit(1'b1, 1'b0);
      probe(100, 36);
      check("slot2_shown", int'(rom_addr), 'h372);

      // Write coinciding with copy lands only in pending
      pulse_commit(1'b0, 1'b1);
      idle();
      frame_start = 1'b1;
      wr_en = 1'b1; wr_idx = 3'd0; wr_glyph = 4'd9;
      tick();
      idle();
      check("copy_with_write_pulse", int'(committed), 1);
      probe(70, 36);
      check("slot0_keeps_old", int'(rom_addr), 'h312);
      pulse_commit(1'b1, 1'b1);
      check("commit_with_fs_pulse", int'(committed), 1);
      probe(70, 36);
      check("slot0_shows_9", int'(rom_addr), 'h392);
      pulse_commit(1'b1, 1'b0);
      check("absorbed_commit_no_rearm", int'(committed), 0);

      // Asynchronous reset while a foreground pixel is on screen
      for (int k = 0; k < 3; k++) probe(82, 44);
      check("pix_before_reset", int'(pixel_on), 1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_pixel", int'(pixel_on), 0);
      check("async_reset_addr", int'(rom_addr), 'h300);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      for (int xx = 60; xx < 196; xx++) probe(xx, 44);
      probe(82, 44);
      check("blank_after_reset", int'(rom_addr), 'h300);

      // Randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         x           = 10'($urandom_range(40, 220));
         y           = 10'($urandom_range(20, 80));
         video_on    = ($urandom_range(0, 7) != 0);
         wr_en       = ($urandom_range(0, 7) == 0);
         wr_idx      = 3'($urandom);
         wr_glyph    = 4'($urandom);
         commit      = ($urandom_range(0, 15) == 0);
         frame_start = ($urandom_range(0, 31) == 0);
         tick();
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/digit_text_renderer.md
Name: digit_text_renderer

Overview:
- Pixel-pipeline controller that drives the 8x16 digit glyph ROM (codes 0x30-0x3C, one-cycle registered-address read latency) to draw one row of up to 8 calculator characters on the VGA raster.
- Holds a double-buffered glyph string: the CPU/calculator core writes a pending buffer, and the buffer is committed to the displayed buffer only at frame start (tear-free).
- Sits between the VGA sync generator and the RGB mux; owns the ROM address port.

Parameters:
- X0, 64, left pixel column of text box (10-bit)
- Y0, 32, top pixel row of text box (10-bit)
- NCHARS, 8, characters in box (1..8)
- SCALE_SHIFT, 1, glyph magnification = 2^SCALE_SHIFT (0..2)

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high reset
- x  in  10  current pixel column from sync generator
- y  in  10  current pixel row
- video_on  in  1  visible-area flag
- frame_start  in  1  single-cycle pulse at start of vertical blank
- wr_en  in  1  write pending glyph
- wr_idx  in  3  character slot (0 = leftmost)
- wr_glyph  in  4  glyph index: 0-9 digit, 10 '-', 11 'A', 12 'N', 13-15 blank
- commit  in  1  request copy of pending to active at next frame_start
- rom_addr  out  11  ROM address
- rom_data  in  8  ROM row data, valid 1 cycle after rom_addr
- pixel_on  out  1  foreground pixel, aligned 3 cycles after x/y
- committed  out  1  one-cycle pulse when copy happened

Behaviour:
- Reset (async): pending and active buffers = 4'hF (blank); commit_pend = 0; rom_addr = 11'h300; pixel_on = 0; committed = 0; all pipeline valid bits = 0.
- Region: rx = x - X0, ry = y - Y0 (unsigned, 10-bit); in_box = video_on & x >= X0 & x < X0 + NCHARS*(8<<S) & y >= Y0 & y < Y0 + (16<<S).
- char = rx >> (3+S); col = (rx >> S) & 7; row = (ry >> S) & 15.
- Stage 1 (t+1): rom_addr <= {3'b011, glyph+0, row} for glyph 0-12, i.e. 0x300 + glyph*16 + row. Blank glyph or !in_box -> rom_addr = 11'h300 and vis1 = 0; otherwise vis1 = 1. col1 <= col.
- Stage 2 (t+2): vis2, col2 delayed; rom_data valid this cycle.
- Stage 3 (t+3): pixel_on <= vis2 & rom_data[7 - col2]. Column 0 = MSB. Total latency fixed at 3 clocks; the sync generator delays hsync/vsync by 3 to match.
- Writes: wr_en stores wr_glyph into pending[wr_idx] the same edge. wr_idx >= NCHARS is ignored.
- commit sets commit_pend (sticky). Repeated commits before frame_start collapse into one.
- On frame_start with commit_pend, or with commit asserted the same cycle: active <= pending (contents before this edge's write), commit_pend <= 0, committed = 1 the next cycle.
- frame_start without a pending commit: no change, committed = 0.
- wr_en simultaneous with copy: the write lands in pending only and is shown after the next commit.
- commit simultaneous with copy: absorbed by that copy. It does not re-arm.
- Active buffer is read only by the pipeline and changes only at frame_start, so no mid-frame tearing.
- Reset mid-frame: pipeline flushes and pixel_on = 0 immediately. The display stays blank until a write, commit and frame_start sequence.
- x/y wrap at raster edges needs no special handling; the subtract underflows to a large rx, which falls outside in_box.

Test Plan:
- Reset then sweep full frame with video_on=1 -> pixel_on = 0 everywhere, rom_addr = 0x300, committed never pulses.
- (X0=64, Y0=32, S=1) write slot0=1, commit, frame_start; drive x=64..79, y=36 -> committed pulses once; rom_addr = 0x312 one cycle later; pixel_on high for x=70..73 only, 3 cycles after each x.
- Write slot1=10 ('-'), commit, frame_start, y=32+2*6=44, x=80..95 -> rom_addr 0x3A6; pixel_on for x=82..93.
- Write slot2=7 without commit, then frame_start -> slot2 still blank (pixel_on 0, rom_addr 0x300). After commit plus the next frame_start -> glyph 7 shown.
- wr_en (slot0=9) in the same cycle as frame_start with commit_pend set -> active slot0 keeps its old glyph; pending holds 9; after a second commit and frame_start -> 9 displayed.
- Assert reset while pixel_on=1 mid-line -> pixel_on=0 and rom_addr=0x300 asynchronously. All slots read blank after release.
